// File: rtl/stack_ctrl.sv
// stack_ctrl: LIFO controller for the return-address and data stacks.
// Optional macro STACK_CTRL_WRAP_EN turns push-on-full into a circular overwrite.
module stack_ctrl #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             activar,
  input  logic             push,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             ovf,
  output logic             unf
);

  localparam logic [AW-1:0] SP1  = AW'(1);
  localparam logic [AW:0]   CNT1 = (AW+1)'(1);
  localparam logic [AW:0]   CMAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    sp;
  logic [AW-1:0]    sp_m1;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;
  logic             wr;

  assign sp_m1   = sp - SP1;
  assign count   = cnt;
  assign full    = (cnt == CMAX);
  assign empty   = (cnt == '0);
  assign top     = empty ? '0 : mem[sp_m1];
  assign do_push = ~clear & activar & push;
  assign do_pop  = ~clear & activar & ~push;

`ifdef STACK_CTRL_WRAP_EN
  assign wr = reset & do_push;
`else
  assign wr = reset & do_push & ~full;
`endif

  // Storage write; contents survive reset, reset at the edge blocks it.
  always_ff @(posedge clk) begin
    if (wr) mem[sp] <= din;
  end

  // Pointer, occupancy and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (clear) begin
      sp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (do_push) begin
      if (!full) begin
        sp  <= sp + SP1;
        cnt <= cnt + CNT1;
      end else begin
        ovf <= 1'b1;
`ifdef STACK_CTRL_WRAP_EN
        sp  <= sp + SP1;
`endif
      end
    end else if (do_pop) begin
      if (!empty) begin
        sp  <= sp_m1;
        cnt <= cnt - CNT1;
      end else begin
        unf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: scoreboard bench for stack_ctrl.
// Reference model is a plain SV queue used as a LIFO.
module tb_stack_ctrl;

  localparam int W = 10;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         activar;
  logic         push;
  logic         clear;
  logic [W-1:0] din;
  logic [W-1:0] top;
  logic         full;
  logic         empty;
  logic [4:0]   count;
  logic         ovf;
  logic         unf;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int top;
    int cnt;
    bit ovf;
    bit unf;
  } snap_t;

  snap_t exp_q[$];
  int    stk[$];
  bit    m_ovf;
  bit    m_unf;

  stack_ctrl #(.WIDTH(W), .DEPTH(D), .AW(4)) dut (
    .clk(clk), .reset(reset), .activar(activar),
    .push(push), .clear(clear), .din(din),
    .top(top), .full(full), .empty(empty),
    .count(count), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  function automatic void check(string nm, int a, int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endfunction

  function automatic void model_reset();
    stk.delete();
    m_ovf = 0;
    m_unf = 0;
  endfunction

  function automatic void model_step(bit c, bit a, bit p, int d);
    if (c) begin
      model_reset();
    end else if (a && p) begin
      if (stk.size() < D) stk.push_back(d);
      else begin
        m_ovf = 1;
`ifdef STACK_CTRL_WRAP_EN
        void'(stk.pop_front());
        stk.push_back(d);
`endif
      end
    end else if (a) begin
      if (stk.size() > 0) void'(stk.pop_back());
      else m_unf = 1;
    end
  endfunction

  function automatic void expect_now();
    snap_t s;
    s.top = (stk.size() > 0) ? stk[$] : 0;
    s.cnt = stk.size();
    s.ovf = m_ovf;
    s.unf = m_unf;
    exp_q.push_back(s);
  endfunction

  task automatic cyc(bit c, bit a, bit p, int d);
    clear   = c;
    activar = a;
    push    = p;
    din     = W'(d);
    @(posedge clk);
    #1;
    model_step(c, a, p, d);
    expect_now();
    clear   = 0;
    activar = 0;
  endtask

  // Monitor: compare each presented output snapshot against the scoreboard.
  initial begin
    snap_t s;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        check("top",   int'(top),   s.top);
        check("count", int'(count), s.cnt);
        check("full",  int'(full),  int'(s.cnt == D));
        check("empty", int'(empty), int'(s.cnt == 0));
        check("ovf",   int'(ovf),   int'(s.ovf));
        check("unf",   int'(unf),   int'(s.unf));
      end
    end
  end

  initial begin
    reset = 0; activar = 0; push = 0; clear = 0; din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    reset = 1;
    expect_now();

    cyc(0, 0, 1, 'h3FF);
    cyc(0, 1, 1, 'h011);
    cyc(0, 1, 1, 'h022);
    cyc(0, 1, 1, 'h033);
    repeat (3) cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);

    for (int i = 1; i <= D; i++) cyc(0, 1, 1, i);
    cyc(0, 1, 1, 'h0AA);
    repeat (D) cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);

    cyc(0, 1, 1, 'h005);
    cyc(1, 1, 1, 'h006);

    cyc(0, 1, 1, 'h100);
    cyc(0, 1, 1, 'h101);
    @(negedge clk);
    #1;
    reset = 0;
    #1;
    check("arst_count", int'(count), 0);
    check("arst_empty", int'(empty), 1);
    check("arst_top",   int'(top),   0);
    check("arst_ovf",   int'(ovf),   0);
    check("arst_unf",   int'(unf),   0);
    @(posedge clk);
    #1;
    reset = 1;
    model_reset();
    expect_now();
    cyc(0, 1, 0, 0);

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 29) == 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 99) < 55,
          int'($urandom_range(0, 1023)));
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Controller for the hardware LIFO stacks driven by the control unit: the subroutine return-address stack (call/return) and the data stack (push/pop of register data).
- Owns the stack storage, stack pointer and occupancy count; exposes the current top-of-stack combinationally so a single-cycle return or pop reads it in the same cycle it is consumed.
- Flags overflow and underflow so the system can detect runaway recursion or unbalanced pops.
- One instance is built per stack.

Parameters:
- WIDTH, 10, entry width in bits (10 = PC width for the return stack; set to 8 for the data stack).
- DEPTH, 16, number of entries; must be a power of two, at least 2.
- AW, 4, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- activar  input  1  operation enable; no state change when 0.
- push  input  1  operation select when activar=1: 1 = push, 0 = pop.
- clear  input  1  synchronous flush of the stack.
- din  input  WIDTH  data to push.
- top  output  WIDTH  current top-of-stack entry; 0 when empty.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  AW+1  number of valid entries, 0..DEPTH.
- ovf  output  1  sticky overflow flag.
- unf  output  1  sticky underflow flag.

Behaviour:
- Reset (reset=0, asynchronous): sp=0, count=0, ovf=0, unf=0; therefore top=0, empty=1, full=0. Storage contents are not reset. Reset asserted mid-operation aborts it; no write occurs on that edge.
- Storage: DEPTH x WIDTH register array. sp points to the next free slot; all pointer arithmetic is modulo DEPTH.
- top = mem[(sp-1) mod DEPTH] when count>0, else 0. It is purely combinational, so it reflects a push on the cycle after the edge.
- Priority per rising edge: clear > (activar & push) > (activar & ~push) > idle.
- clear=1: sp=0, count=0, ovf=0, unf=0. Any simultaneous push or pop is discarded.
- Push, not full: mem[sp]<=din; sp<=sp+1; count<=count+1.
- Push, full: no write, sp and count unchanged, ovf<=1.
- Pop, not empty: sp<=sp-1; count<=count-1. The popped value is the top presented during the pop cycle. Latency is zero for read and one edge for pointer update.
- Pop, empty: no change to sp or count; unf<=1.
- activar=0: push and din are ignored; state holds.
- ovf and unf stay set until clear or reset. Subsequent legal operations do not clear them.
- full and empty are combinational decodes of count.

Optional Feature:
- Macro: STACK_CTRL_WRAP_EN.
- Defined: push on full is accepted as a circular overwrite. mem[sp]<=din, sp<=sp+1, count stays DEPTH, ovf<=1. The oldest entry is lost, and later pops return the newest DEPTH entries in LIFO order.
- Undefined: push on full is dropped as described in Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release -> count=0, empty=1, full=0, top=0, ovf=unf=0; activar=0 with push=1, din=0x3FF -> count stays 0.
- LIFO order: push 0x011, 0x022, 0x033 -> count=3, top=0x033. Pop x3 -> top reads 0x033, 0x022, 0x011 in the pop cycles; then empty=1, top=0.
- Overflow (WRAP undefined, DEPTH=16): push 1..16 -> full=1. Push 0x0AA -> ovf=1, count=16, top=16. Pop 16 times -> values 16..1.
- Overflow (WRAP defined): push 1..17 -> ovf=1, count=16, top=17. Pop 16 times -> 17..2.
- Underflow and clear: pop on empty -> unf=1, count=0. Push 0x005, then clear=1 with activar=1, push=1, din=0x006 on the same edge -> count=0, ovf=unf=0, top=0.
- Async reset mid-sequence: push 0x100, 0x101, then assert reset between clock edges -> outputs return to reset values immediately without waiting for a clock edge. After release, pop -> unf=1.
